// File: rtl/slc3_stim_pkg.sv
// Shared state encoding and default sizing for the SLC-3 stimulus sequencer.
package slc3_stim_pkg;

    localparam int unsigned DefSwW      = 10;
    localparam int unsigned DefDepth    = 8;
    localparam int unsigned DefPulseCyc = 2;
    localparam int unsigned DefTimeout  = 1024;

    typedef enum logic [3:0] {
        StIdle,
        StReset,
        StRelease,
        StWaitPause,
        StApply,
        StWaitResume,
        StWaitCheck,
        StCheck,
        StDone
    } state_e;

endpackage

// File: rtl/slc3_stim_seq_if.sv
// CPU-side bundle of the stimulus sequencer: switch/press outputs and the CPU pause/result taps.
interface slc3_stim_seq_if
    import slc3_stim_pkg::*;
#(
    parameter int unsigned SW_W = DefSwW
);
    logic [SW_W-1:0] SW;
    logic            Run_n;
    logic            Continue_n;
    logic            Pause_in;
    logic [15:0]     Result_in;

    modport master (
        output SW,
        output Run_n,
        output Continue_n,
        input  Pause_in,
        input  Result_in
    );

    modport slave (
        input  SW,
        input  Run_n,
        input  Continue_n,
        output Pause_in,
        output Result_in
    );
endinterface

// File: rtl/stim_timer.sv
// Shared down-counter for press widths and wait timeouts: loads, counts to zero, then holds.
module stim_timer #(
    parameter int unsigned Width = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    output logic             expired_o
);
    logic [Width-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - Width'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == '0);
endmodule

// File: rtl/slc3_stim_seq.sv
// SLC-3 stimulus sequencer: resets the CPU, applies stored switch vectors and tallies results.
// Defining SLC3_STIM_TIMEOUT_EN adds a cycle limit on every wait for a Pause_in edge.
module slc3_stim_seq
    import slc3_stim_pkg::*;
#(
    parameter int unsigned SW_W      = DefSwW,
    parameter int unsigned DEPTH     = DefDepth,
    parameter int unsigned PULSE_CYC = DefPulseCyc,
    parameter int unsigned TIMEOUT   = DefTimeout
) (
    input  logic                     Clk,
    input  logic                     Reset_n,
    input  logic                     Vec_we,
    input  logic [$clog2(DEPTH)-1:0] Vec_addr,
    input  logic [SW_W-1:0]          Vec_sw,
    input  logic [15:0]              Vec_exp,
    input  logic [$clog2(DEPTH):0]   Count,
    input  logic                     Start,
    output logic                     Busy,
    output logic                     Done,
    output logic [$clog2(DEPTH):0]   Pass_cnt,
    output logic [$clog2(DEPTH):0]   Fail_cnt,
    output logic [$clog2(DEPTH)-1:0] Cur_idx,
    slc3_stim_seq_if.master          cpu
);
    localparam int unsigned IW = $clog2(DEPTH);
    localparam int unsigned CW = IW + 1;
`ifdef SLC3_STIM_TIMEOUT_EN
    localparam bit TimeoutEn = 1'b1;
`else
    localparam bit TimeoutEn = 1'b0;
`endif
    // Without the timeout the shared timer only needs to span a press width.
    localparam int unsigned TimerMax = (TimeoutEn && (TIMEOUT > PULSE_CYC)) ? TIMEOUT : PULSE_CYC;
    localparam int unsigned TW       = (TimerMax > 1) ? $clog2(TimerMax) : 1;

    logic [SW_W-1:0] sw_mem  [DEPTH];
    logic [15:0]     exp_mem [DEPTH];

    state_e          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [IW-1:0]   last_q, last_d, last_start;
    logic [CW-1:0]   pass_q, pass_d;
    logic [CW-1:0]   fail_q, fail_d;
    logic [SW_W-1:0] sw_q, sw_d;
    logic [15:0]     res_q, res_d;
    logic            tmr_load, tmr_expired, wait_expired;
    logic [TW-1:0]   tmr_val;

    // Vector store is deliberately not reset so vectors survive a CPU-side abort.
    always_ff @(posedge Clk) begin
        if (Vec_we) begin
            sw_mem[Vec_addr]  <= Vec_sw;
            exp_mem[Vec_addr] <= Vec_exp;
        end
    end

    always_comb begin
        if (Count == '0) begin
            last_start = '0;
        end else if (Count > CW'(DEPTH)) begin
            last_start = IW'(DEPTH - 1);
        end else begin
            last_start = IW'(Count - CW'(1));
        end
    end

`ifdef SLC3_STIM_TIMEOUT_EN
    assign wait_expired = tmr_expired;
`else
    assign wait_expired = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        last_d  = last_q;
        pass_d  = pass_q;
        fail_d  = fail_q;
        sw_d    = sw_q;
        res_d   = res_q;
        unique case (state_q)
            StIdle: begin
                if (Start) begin
                    state_d = StReset;
                    idx_d   = '0;
                    pass_d  = '0;
                    fail_d  = '0;
                    last_d  = last_start;
                end
            end
            StReset: begin
                if (tmr_expired) state_d = StRelease;
            end
            StRelease: begin
                if (tmr_expired) state_d = StWaitPause;
            end
            StWaitPause: begin
                if (cpu.Pause_in) begin
                    state_d = StApply;
                    sw_d    = sw_mem[idx_q];
                end else if (wait_expired) begin
                    state_d = StDone;
                    fail_d  = fail_q + CW'(1);
                end
            end
            StApply: begin
                if (tmr_expired) state_d = StWaitResume;
            end
            StWaitResume: begin
                if (!cpu.Pause_in) begin
                    state_d = StWaitCheck;
                end else if (wait_expired) begin
                    state_d = StDone;
                    fail_d  = fail_q + CW'(1);
                end
            end
            StWaitCheck: begin
                if (cpu.Pause_in) begin
                    state_d = StCheck;
                    res_d   = cpu.Result_in;
                end else if (wait_expired) begin
                    state_d = StDone;
                    fail_d  = fail_q + CW'(1);
                end
            end
            StCheck: begin
                if (res_q == exp_mem[idx_q]) begin
                    pass_d = pass_q + CW'(1);
                end else begin
                    fail_d = fail_q + CW'(1);
                end
                if (idx_q == last_q) begin
                    state_d = StDone;
                end else begin
                    idx_d   = idx_q + IW'(1);
                    sw_d    = sw_mem[idx_d];
                    state_d = StApply;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Every state change restarts the timer with the budget of the state being entered.
    always_comb begin
        tmr_load = (state_d != state_q);
        tmr_val  = TW'(PULSE_CYC - 1);
`ifdef SLC3_STIM_TIMEOUT_EN
        if ((state_d == StWaitPause) || (state_d == StWaitResume) || (state_d == StWaitCheck)) begin
            tmr_val = TW'(TIMEOUT - 1);
        end
`endif
    end

    stim_timer #(
        .Width (TW)
    ) u_timer (
        .clk_i      (Clk),
        .rst_ni     (Reset_n),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .expired_o  (tmr_expired)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= StIdle;
            idx_q   <= '0;
            last_q  <= '0;
            pass_q  <= '0;
            fail_q  <= '0;
            sw_q    <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
            sw_q    <= sw_d;
            res_q   <= res_d;
        end
    end

    assign cpu.SW         = sw_q;
    assign cpu.Run_n      = !((state_q == StReset) || (state_q == StRelease));
    assign cpu.Continue_n = !((state_q == StReset) || (state_q == StApply));
    assign Busy           = (state_q != StIdle);
    assign Done           = (state_q == StDone);
    assign Pass_cnt       = pass_q;
    assign Fail_cnt       = fail_q;
    assign Cur_idx        = idx_q;
endmodule

// File: tb/tb_slc3_stim_seq.sv
// Directed bench for slc3_stim_seq with a small SLC-3 model that echoes SW as its result.
module tb_slc3_stim_seq;
    logic        clk;
    logic        rst_n;
    logic        vec_we;
    logic [2:0]  vec_addr;
    logic [9:0]  vec_sw;
    logic [15:0] vec_exp;
    logic [3:0]  count;
    logic        start;
    logic        busy;
    logic        done;
    logic [3:0]  pass_cnt;
    logic [3:0]  fail_cnt;
    logic [2:0]  cur_idx;
    logic        cpu_en;

    int   n_vec;
    int   n_err;
    int   run_low, cont_pulses, cont_min, cont_max, done_n, rise_k, done_k;
    logic seq_to, busy_first;

    slc3_stim_seq_if #(.SW_W(10)) bus ();

    slc3_stim_seq #(
        .SW_W      (10),
        .DEPTH     (8),
        .PULSE_CYC (2),
        .TIMEOUT   (16)
    ) dut (
        .Clk      (clk),
        .Reset_n  (rst_n),
        .Vec_we   (vec_we),
        .Vec_addr (vec_addr),
        .Vec_sw   (vec_sw),
        .Vec_exp  (vec_exp),
        .Count    (count),
        .Start    (start),
        .Busy     (busy),
        .Done     (done),
        .Pass_cnt (pass_cnt),
        .Fail_cnt (fail_cnt),
        .Cur_idx  (cur_idx),
        .cpu      (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // CPU model: halts 4 cycles after Run release or after a Continue press is released.
    initial begin : cpu_model
        int dly;
        int cst;
        bus.Pause_in  = 1'b0;
        bus.Result_in = '0;
        dly = 3;
        cst = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!cpu_en || !rst_n || !bus.Run_n) begin
                bus.Pause_in = 1'b0;
                cst = 0;
                dly = 3;
            end else if (cst == 0) begin
                if (dly == 0) begin
                    bus.Pause_in  = 1'b1;
                    bus.Result_in = 16'(bus.SW);
                    cst = 1;
                end else begin
                    dly--;
                end
            end else if (cst == 1) begin
                if (!bus.Continue_n) begin
                    bus.Pause_in = 1'b0;
                    cst = 2;
                end
            end else if (bus.Continue_n) begin
                cst = 0;
                dly = 3;
            end
        end
    end

    task automatic write_vec(input int a, input logic [9:0] sw, input logic [15:0] e);
        vec_we   = 1'b1;
        vec_addr = 3'(a);
        vec_sw   = sw;
        vec_exp  = e;
        @(posedge clk);
        #1;
        vec_we   = 1'b0;
    endtask

    // Pulses Start, then watches presses and Done until 3 cycles past Done or the budget runs out.
    task automatic run_seq(input logic [3:0] cnt, input int budget, input int restart_k);
        int  k;
        int  w;
        bit  fin;
        count = cnt;
        start = 1'b1;
        @(posedge clk);
        #1;
        start       = 1'b0;
        busy_first  = busy;
        run_low     = 0;
        cont_pulses = 0;
        cont_min    = 1000;
        cont_max    = 0;
        done_n      = 0;
        rise_k      = -1;
        done_k      = -1;
        w           = 0;
        k           = 0;
        fin         = 1'b0;
        while (!fin && k < budget) begin
            if (!bus.Run_n) run_low++;
            else if (rise_k < 0 && run_low > 0) rise_k = k;
            if (!bus.Continue_n) begin
                w++;
            end else if (w > 0) begin
                cont_pulses++;
                if (w < cont_min) cont_min = w;
                if (w > cont_max) cont_max = w;
                w = 0;
            end
            if (done) begin
                done_n++;
                if (done_k < 0) done_k = k;
            end
            start = (k == restart_k);
            if (done_k >= 0 && k >= done_k + 3) fin = 1'b1;
            else begin
                @(posedge clk);
                #1;
                k++;
            end
        end
        start  = 1'b0;
        seq_to = (done_k < 0);
    endtask

    task automatic test_reset();
        #1;
        rst_n = 1'b0;
        #2;
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset.busy: got %b want 0", busy); end
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset.done: got %b want 0", done); end
        n_vec++; if (bus.Run_n !== 1'b1) begin
            n_err++; $display("FAIL reset.run_n: got %b want 1", bus.Run_n); end
        n_vec++; if (bus.Continue_n !== 1'b1) begin
            n_err++; $display("FAIL reset.continue_n: got %b want 1", bus.Continue_n); end
        n_vec++; if (bus.SW !== 10'h000) begin
            n_err++; $display("FAIL reset.sw: got %h want 000", bus.SW); end
        n_vec++; if (pass_cnt !== 4'd0) begin
            n_err++; $display("FAIL reset.pass_cnt: got %0d want 0", pass_cnt); end
        n_vec++; if (fail_cnt !== 4'd0) begin
            n_err++; $display("FAIL reset.fail_cnt: got %0d want 0", fail_cnt); end
        n_vec++; if (cur_idx !== 3'd0) begin
            n_err++; $display("FAIL reset.cur_idx: got %0d want 0", cur_idx); end
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_vec++; if (busy !== 1'b0) begin
            n_err++; $display("FAIL reset.idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_pass_two();
        write_vec(0, 10'h0B6, 16'h00B6);
        write_vec(1, 10'h32D, 16'h032D);
        run_seq(4'd2, 300, -1);
        n_vec++; if (seq_to !== 1'b0) begin n_err++; $display("FAIL pass_two.timeout: got no Done"); end
        n_vec++; if (busy_first !== 1'b1) begin
            n_err++; $display("FAIL pass_two.busy_first: got %b want 1", busy_first); end
        n_vec++; if (pass_cnt !== 4'd2) begin
            n_err++; $display("FAIL pass_two.pass_cnt: got %0d want 2", pass_cnt); end
        n_vec++; if (fail_cnt !== 4'd0) begin
            n_err++; $display("FAIL pass_two.fail_cnt: got %0d want 0", fail_cnt); end
        n_vec++; if (done_n != 1) begin
            n_err++; $display("FAIL pass_two.done_pulses: got %0d want 1", done_n); end
        n_vec++; if (run_low != 4) begin
            n_err++; $display("FAIL pass_two.run_low: got %0d want 4", run_low); end
        n_vec++; if (rise_k != 4) begin
            n_err++; $display("FAIL pass_two.run_rise: got %0d want 4", rise_k); end
        n_vec++; if (cont_min != 2 || cont_max != 2) begin
            n_err++; $display("FAIL pass_two.cont_width: got %0d..%0d want 2..2", cont_min, cont_max);
        end
        n_vec++; if (cont_pulses != 3) begin
            n_err++; $display("FAIL pass_two.cont_pulses: got %0d want 3", cont_pulses); end
        n_vec++; if (bus.SW !== 10'h32D) begin
            n_err++; $display("FAIL pass_two.sw_hold: got %h want 32d", bus.SW); end
        n_vec++; if (cur_idx !== 3'd1) begin
            n_err++; $display("FAIL pass_two.cur_idx: got %0d want 1", cur_idx); end
        n_vec++; if (busy !== 1'b0) begin
            n_err++; $display("FAIL pass_two.busy_end: got %b want 0", busy); end
    endtask

    task automatic test_fail_one();
        write_vec(1, 10'h32D, 16'h0000);
        run_seq(4'd2, 300, -1);
        n_vec++; if (seq_to !== 1'b0) begin n_err++; $display("FAIL fail_one.timeout: got no Done"); end
        n_vec++; if (pass_cnt !== 4'd1) begin
            n_err++; $display("FAIL fail_one.pass_cnt: got %0d want 1", pass_cnt); end
        n_vec++; if (fail_cnt !== 4'd1) begin
            n_err++; $display("FAIL fail_one.fail_cnt: got %0d want 1", fail_cnt); end
    endtask

    task automatic test_back_to_back();
        run_seq(4'd2, 300, 20);
        n_vec++; if (pass_cnt !== 4'd1 || fail_cnt !== 4'd1) begin
            n_err++; $display("FAIL busy_start.counts: got %0d/%0d want 1/1", pass_cnt, fail_cnt); end
        n_vec++; if (run_low != 4 || cont_pulses != 3) begin
            n_err++; $display("FAIL busy_start.presses: got run %0d cont %0d want 4 3",
                              run_low, cont_pulses);
        end
        n_vec++; if (done_n != 1 || busy !== 1'b0) begin
            n_err++; $display("FAIL busy_start.done: got %0d busy %b want 1 0", done_n, busy); end
        run_seq(4'd2, 300, -1);
        n_vec++; if (pass_cnt !== 4'd1 || fail_cnt !== 4'd1) begin
            n_err++; $display("FAIL back_to_back.counts: got %0d/%0d want 1/1", pass_cnt, fail_cnt);
        end
    endtask

    task automatic test_count_clamp();
        logic [9:0] sw_tab [8];
        sw_tab = '{10'd5, 10'd42, 10'd79, 10'd116, 10'd153, 10'd190, 10'd227, 10'd264};
        for (int i = 0; i < 8; i++) begin
            write_vec(i, sw_tab[i], (i == 5) ? 16'hFFFF : 16'(sw_tab[i]));
        end
        run_seq(4'd11, 600, -1);
        n_vec++; if (seq_to !== 1'b0) begin n_err++; $display("FAIL clamp.timeout: got no Done"); end
        n_vec++; if (pass_cnt !== 4'd7 || fail_cnt !== 4'd1) begin
            n_err++; $display("FAIL clamp.counts: got %0d/%0d want 7/1", pass_cnt, fail_cnt); end
        n_vec++; if (cur_idx !== 3'd7) begin
            n_err++; $display("FAIL clamp.cur_idx: got %0d want 7", cur_idx); end
        n_vec++; if (cont_pulses != 9) begin
            n_err++; $display("FAIL clamp.cont_pulses: got %0d want 9", cont_pulses); end
        n_vec++; if (bus.SW !== 10'd264) begin
            n_err++; $display("FAIL clamp.sw_hold: got %0d want 264", bus.SW); end
    endtask

    task automatic test_count_zero();
        run_seq(4'd0, 300, -1);
        n_vec++; if (pass_cnt !== 4'd1 || fail_cnt !== 4'd0) begin
            n_err++; $display("FAIL count0.counts: got %0d/%0d want 1/0", pass_cnt, fail_cnt); end
        n_vec++; if (cont_pulses != 2 || cur_idx !== 3'd0) begin
            n_err++; $display("FAIL count0.progress: got cont %0d idx %0d want 2 0",
                              cont_pulses, cur_idx);
        end
        n_vec++; if (bus.SW !== 10'd5) begin
            n_err++; $display("FAIL count0.sw: got %0d want 5", bus.SW); end
    endtask

    task automatic test_stuck_pause();
        cpu_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
`ifdef SLC3_STIM_TIMEOUT_EN
        run_seq(4'd2, 200, -1);
        n_vec++; if (seq_to !== 1'b0) begin n_err++; $display("FAIL timeout.no_done: got no Done"); end
        n_vec++; if (done_k - rise_k != 16) begin
            n_err++; $display("FAIL timeout.latency: got %0d want 16", done_k - rise_k); end
        n_vec++; if (fail_cnt !== 4'd1 || pass_cnt !== 4'd0) begin
            n_err++; $display("FAIL timeout.counts: got %0d/%0d want 0/1", pass_cnt, fail_cnt); end
        n_vec++; if (done_n != 1) begin
            n_err++; $display("FAIL timeout.done_pulses: got %0d want 1", done_n); end
`else
        run_seq(4'd2, 60, -1);
        n_vec++; if (seq_to !== 1'b1 || done_n != 0) begin
            n_err++; $display("FAIL stuck.waits: got done pulses %0d want 0", done_n); end
        n_vec++; if (busy !== 1'b1) begin
            n_err++; $display("FAIL stuck.busy: got %b want 1", busy); end
        n_vec++; if (pass_cnt !== 4'd0 || fail_cnt !== 4'd0) begin
            n_err++; $display("FAIL stuck.counts: got %0d/%0d want 0/0", pass_cnt, fail_cnt); end
        #3;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
`endif
        cpu_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        int k;
        int dn;
        count = 4'd2;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        k = 0;
        while (k < 100 && !(bus.Continue_n === 1'b0 && bus.Run_n === 1'b1)) begin
            @(posedge clk);
            #1;
            k++;
        end
        n_vec++; if (k >= 100) begin n_err++; $display("FAIL reset_mid.reach_apply: got no APPLY"); end
        n_vec++; if (bus.SW !== 10'd5) begin
            n_err++; $display("FAIL reset_mid.apply_sw: got %0d want 5", bus.SW); end
        #3;
        rst_n = 1'b0;
        #1;
        n_vec++; if (bus.Continue_n !== 1'b1) begin
            n_err++; $display("FAIL reset_mid.continue_n: got %b want 1", bus.Continue_n); end
        n_vec++; if (bus.SW !== 10'd0) begin
            n_err++; $display("FAIL reset_mid.sw: got %0d want 0", bus.SW); end
        n_vec++; if (busy !== 1'b0 || bus.Run_n !== 1'b1) begin
            n_err++; $display("FAIL reset_mid.idle: got busy %b run_n %b want 0 1", busy, bus.Run_n);
        end
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        dn = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (done) dn++;
        end
        n_vec++; if (dn != 0 || busy !== 1'b0) begin
            n_err++; $display("FAIL reset_mid.abort: got done %0d busy %b want 0 0", dn, busy); end
        run_seq(4'd1, 300, -1);
        n_vec++; if (pass_cnt !== 4'd1 || fail_cnt !== 4'd0) begin
            n_err++; $display("FAIL reset_mid.store_kept: got %0d/%0d want 1/0", pass_cnt, fail_cnt);
        end
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        rst_n    = 1'b1;
        vec_we   = 1'b0;
        vec_addr = '0;
        vec_sw   = '0;
        vec_exp  = '0;
        count    = '0;
        start    = 1'b0;
        cpu_en   = 1'b1;
        test_reset();
        test_pass_two();
        test_fail_one();
        test_back_to_back();
        test_count_clamp();
        test_count_zero();
        test_stuck_pause();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
